// File: rtl/lcd_result_driver_if.sv
// lcd_result_driver_if: the HD44780 character-LCD pin bundle.
// The driver owns the bus through the master modport; the LCD side, or a
// monitor, observes it through the slave modport.
interface lcd_result_driver_if;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;

    modport master (output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on);
    modport slave  (input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on);
endinterface

// File: rtl/lcd_result_driver.sv
// lcd_result_driver: shows the 32-nibble result buffer on a 16x2 HD44780 LCD.
// After power-up it sends the initialisation commands. It then writes
// nibbles 0-15 as hex characters on line 1 and nibbles 16-31 on line 2.
// The display is redrawn on request, always from a snapshot of the buffer
// that is taken when the frame starts.
// Optional feature: define LCD_AUTO_REFRESH_EN to redraw automatically
// whenever lcd_buffer differs from the last snapshot.
module lcd_result_driver #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned EN_CYCLES      = 25,
    parameter int unsigned CMD_WAIT       = 2500,
    parameter int unsigned CLEAR_WAIT     = 82000
) (
    input  logic                       s_axi_aclk,
    input  logic                       reset,
    input  logic [127:0]               lcd_buffer,
    input  logic                       refresh,
    lcd_result_driver_if.master        lcd,
    output logic                       busy,
    output logic                       init_done,
    output logic                       frame_done
);

    // Every down-counter load fits in the widest delay.
    localparam int unsigned MAX_AB  = (POWERUP_CYCLES > CLEAR_WAIT) ? POWERUP_CYCLES : CLEAR_WAIT;
    localparam int unsigned MAX_CD  = (EN_CYCLES > CMD_WAIT) ? EN_CYCLES : CMD_WAIT;
    localparam int unsigned MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int          CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LOAD  = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLEAR_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [5:0] IDX_INIT_LAST   = 6'd3;
    localparam logic [5:0] IDX_FRAME_FIRST = 6'd4;
    localparam logic [5:0] IDX_LAST        = 6'd37;

    typedef enum logic [1:0] {ST_POWERUP, ST_INIT, ST_FRAME, ST_IDLE} top_e;
    typedef enum logic [1:0] {PH_SETUP, PH_EN_HIGH, PH_HOLD, PH_WAIT} phase_e;

    top_e             top_q;
    phase_e           phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       idx_q;
    logic [127:0]     snap_q;
    logic             pending_q;
    logic [7:0]       data_q;
    logic             rs_q;
    logic             en_q;
    logic             busy_q;
    logic             init_done_q;
    logic             frame_done_q;

    logic [CNT_W-1:0] wait_load_d;
    logic             last_byte_d;
    logic             buf_changed_d;

    // Nibble value 0-15 to its ASCII hex character.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    // Byte idx of the fixed 38-byte sequence as {rs, data}.
    function automatic logic [8:0] seq_byte(input logic [5:0] idx, input logic [127:0] snap);
        logic [5:0] nib;
        nib = (idx <= 6'd20) ? (idx - 6'd5) : (idx - 6'd6);
        case (idx)
            6'd0:    return 9'h038;
            6'd1:    return 9'h00C;
            6'd2:    return 9'h001;
            6'd3:    return 9'h006;
            6'd4:    return 9'h080;
            6'd21:   return 9'h0C0;
            default: begin
                if (idx <= IDX_LAST)
                    return {1'b1, hex_char(snap[{nib[4:0], 2'b00} +: 4])};
                else
                    return 9'h000;
            end
        endcase
    endfunction

`ifdef LCD_AUTO_REFRESH_EN
    assign buf_changed_d = (lcd_buffer != snap_q);
`else
    assign buf_changed_d = 1'b0;
`endif

    // Clear Display needs the long settle time; every other byte uses the short one.
    always_comb begin
        wait_load_d = CMD_LOAD;
        if (!rs_q && data_q == 8'h01)
            wait_load_d = CLR_LOAD;
    end

    assign last_byte_d = (top_q == ST_FRAME) && (idx_q == IDX_LAST);

    // Top sequencer and per-byte strobe timing, with registered LCD outputs.
    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            top_q        <= ST_POWERUP;
            phase_q      <= PH_SETUP;
            cnt_q        <= PWR_LOAD;
            idx_q        <= 6'd0;
            snap_q       <= '0;
            pending_q    <= 1'b0;
            data_q       <= 8'h00;
            rs_q         <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b1;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // A request that arrives while busy is remembered until IDLE.
            if (refresh && top_q != ST_IDLE)
                pending_q <= 1'b1;

            case (top_q)
                ST_POWERUP: begin
                    if (cnt_q == '0) begin
                        top_q          <= ST_INIT;
                        phase_q        <= PH_SETUP;
                        idx_q          <= 6'd0;
                        {rs_q, data_q} <= seq_byte(6'd0, snap_q);
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                ST_IDLE: begin
                    if (refresh || pending_q || buf_changed_d) begin
                        snap_q         <= lcd_buffer;
                        pending_q      <= 1'b0;
                        top_q          <= ST_FRAME;
                        phase_q        <= PH_SETUP;
                        idx_q          <= IDX_FRAME_FIRST;
                        {rs_q, data_q} <= seq_byte(IDX_FRAME_FIRST, snap_q);
                        busy_q         <= 1'b1;
                    end
                end

                default: begin
                    case (phase_q)
                        PH_SETUP: begin
                            phase_q <= PH_EN_HIGH;
                            en_q    <= 1'b1;
                            cnt_q   <= EN_LOAD;
                        end

                        PH_EN_HIGH: begin
                            if (cnt_q == '0) begin
                                phase_q <= PH_HOLD;
                                en_q    <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q - CNT_ONE;
                            end
                        end

                        PH_HOLD: begin
                            phase_q      <= PH_WAIT;
                            cnt_q        <= wait_load_d;
                            // frame_done marks the final wait cycle of the frame.
                            frame_done_q <= last_byte_d && (wait_load_d == '0);
                        end

                        default: begin
                            if (cnt_q == '0) begin
                                if (top_q == ST_INIT && idx_q == IDX_INIT_LAST) begin
                                    // The first frame follows init directly, from a fresh snapshot.
                                    init_done_q    <= 1'b1;
                                    snap_q         <= lcd_buffer;
                                    pending_q      <= 1'b0;
                                    top_q          <= ST_FRAME;
                                    phase_q        <= PH_SETUP;
                                    idx_q          <= IDX_FRAME_FIRST;
                                    {rs_q, data_q} <= seq_byte(IDX_FRAME_FIRST, snap_q);
                                end else if (last_byte_d) begin
                                    top_q  <= ST_IDLE;
                                    busy_q <= 1'b0;
`ifdef LCD_AUTO_REFRESH_EN
                                    if (buf_changed_d)
                                        pending_q <= 1'b1;
`endif
                                end else begin
                                    phase_q        <= PH_SETUP;
                                    idx_q          <= idx_q + 6'd1;
                                    {rs_q, data_q} <= seq_byte(idx_q + 6'd1, snap_q);
                                end
                            end else begin
                                cnt_q        <= cnt_q - CNT_ONE;
                                frame_done_q <= last_byte_d && (cnt_q == CNT_ONE);
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign lcd.lcd_data = data_q;
    assign lcd.lcd_rs   = rs_q;
    assign lcd.lcd_rw   = 1'b0;
    assign lcd.lcd_en   = en_q;
    assign lcd.lcd_on   = 1'b1;
    assign busy         = busy_q;
    assign init_done    = init_done_q;
    assign frame_done   = frame_done_q;

endmodule
